// File: rtl/stream_arb_pkg.sv
// Shared types for the 4:1 round-robin stream arbiter.
package stream_arb_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0] idx_t;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam idx_t PTR_RESET = idx_t'(N_REQ - 1);

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: searches req starting one past ptr and
// returns the first set index.
module rr_pick_4
  import stream_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  idx_t             ptr,
  output logic             gnt_valid,
  output idx_t             gnt_idx
);

  idx_t cand;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    cand      = '0;
    // Offset N_REQ wraps back onto ptr itself, so it is searched last.
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ptr + idx_t'(k);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/stream_arb_4_1.sv
// 4:1 round-robin stream arbiter with a registered output stage.
// Burst locking is built only when STREAM_ARB_4_1_LOCK_EN is defined.
//   state | meaning
//   ARB   | free round-robin arbitration
//   LOCK  | mid-burst, only requester ptr is eligible
module stream_arb_4_1
  import stream_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     d0,
  input  logic [W-1:0]     d1,
  input  logic [W-1:0]     d2,
  input  logic [W-1:0]     d3,
  input  logic [N_REQ-1:0] in_valid,
  input  logic [N_REQ-1:0] in_last,
  output logic [N_REQ-1:0] in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [1:0]       out_src,
  output logic             out_last
);

  logic             room;
  logic             accept;
  logic             gnt_valid;
  idx_t             gnt_idx;
  idx_t             ptr;
  logic [N_REQ-1:0] eligible;
  logic [W-1:0]     d_sel;

  assign room = !out_valid || out_ready;

`ifdef STREAM_ARB_4_1_LOCK_EN
  state_t           state;
  state_t           state_nxt;
  logic [N_REQ-1:0] lock_mask;

  assign lock_mask = {{(N_REQ-1){1'b0}}, 1'b1} << ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    eligible  = in_valid;
    if (state == LOCK) eligible = in_valid & lock_mask;
    if (accept) state_nxt = in_last[gnt_idx] ? ARB : LOCK;
  end
`else
  assign eligible = in_valid;
`endif

  rr_pick_4 u_pick (
    .req       (eligible),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // rst_n gates the handshake so no beat is offered as accepted during reset.
  assign accept   = room && gnt_valid && rst_n;
  assign in_ready = accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;

  always_comb begin
    d_sel = d0;
    case (gnt_idx)
      2'd0: d_sel = d0;
      2'd1: d_sel = d1;
      2'd2: d_sel = d2;
      2'd3: d_sel = d3;
      default: d_sel = d0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
      ptr       <= PTR_RESET;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= d_sel;
      out_src   <= gnt_idx;
      out_last  <= in_last[gnt_idx];
      ptr       <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
